program_loader: RTL

Write-side counterpart of the instruction program memory. Receives a byte stream from the debug/UART receive path, assembles big-endian 32-bit instruction words, and writes them into program memory at word-aligned byte addresses from 0 upward. It stops at the HALT word and signals completion, so the fetch side can then read the loaded program through the memory's read port.

---
 rtl/program_loader.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Assembles big-endian 32-bit words from a byte stream and writes them to program memory from address 0 until HALT.
// Latency: WE is registered one edge after the 4th byte. DONE/ERR rise one edge later. No backpressure: every RX_VALID byte in LOAD is consumed.
// Optional PROGRAM_LOADER_CHECKSUM_EN adds a CHECK state that compares a trailing byte with the mod-256 byte sum.
module program_loader #(
    parameter int          MEM_DEPTH_WORDS = 256,
    parameter logic [31:0] HALT_WORD       = 32'hFFFF_FFFF,
    localparam int         CW              = $clog2(MEM_DEPTH_WORDS + 1)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          START,
    input  logic [7:0]    RX_DATA,
    input  logic          RX_VALID,
    output logic          WE,
    output logic [31:0]   WADDR,
    output logic [31:0]   WDATA,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERR,
    output logic [CW-1:0] WORD_COUNT
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;
`endif

    state_t      state, state_nxt;
    // Only the three earlier bytes need storing; the fourth is taken straight from RX_DATA.
    logic [23:0] asm_q;
    logic [1:0]  byte_cnt;
    logic        pend;
    logic        pend_err;
    logic [31:0] asm_nxt;
    logic        start_ok;
    logic        byte_in;
    logic        word_done;
    logic        ovf;
    logic        is_halt;

    assign asm_nxt   = {asm_q, RX_DATA};
    assign start_ok  = START && (state == S_IDLE || state == S_DONE || state == S_ERROR);
    assign byte_in   = RX_VALID && (state == S_LOAD) && !pend;
    assign word_done = byte_in && (byte_cnt == 2'd3);
    assign ovf       = word_done && (WORD_COUNT == CW'(MEM_DEPTH_WORDS));
    assign is_halt   = word_done && !ovf && (asm_nxt == HALT_WORD);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] sum_q;
    logic       chk_in;

    assign chk_in = RX_VALID && (state == S_CHECK) && !pend;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // pend holds a finished outcome for one cycle so DONE/ERR appear the edge after the deciding byte.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (START) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (pend) begin
                    state_nxt = pend_err ? S_ERROR : S_DONE;
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                else if (is_halt) begin
                    state_nxt = S_CHECK;
                end
`endif
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (pend) begin
                    state_nxt = pend_err ? S_ERROR : S_DONE;
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        BUSY = 1'b0;
        DONE = 1'b0;
        ERR  = 1'b0;
        case (state)
            S_LOAD:  BUSY = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHECK: BUSY = 1'b1;
`endif
            S_DONE:  DONE = 1'b1;
            S_ERROR: ERR  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            asm_q      <= '0;
            byte_cnt   <= '0;
            pend       <= 1'b0;
            pend_err   <= 1'b0;
            WE         <= 1'b0;
            WADDR      <= '0;
            WDATA      <= '0;
            WORD_COUNT <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            WE   <= 1'b0;
            pend <= 1'b0;
            if (WE) begin
                WORD_COUNT <= WORD_COUNT + 1'b1;
            end
            if (start_ok) begin
                asm_q      <= '0;
                byte_cnt   <= '0;
                pend_err   <= 1'b0;
                WORD_COUNT <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                sum_q      <= '0;
`endif
            end else if (byte_in) begin
                asm_q    <= asm_nxt[23:0];
                byte_cnt <= byte_cnt + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                sum_q    <= sum_q + RX_DATA;
`endif
                if (ovf) begin
                    pend     <= 1'b1;
                    pend_err <= 1'b1;
                end else if (word_done) begin
                    WE    <= 1'b1;
                    WADDR <= 32'(WORD_COUNT) << 2;
                    WDATA <= asm_nxt;
`ifndef PROGRAM_LOADER_CHECKSUM_EN
                    if (is_halt) begin
                        pend     <= 1'b1;
                        pend_err <= 1'b0;
                    end
`endif
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            else if (chk_in) begin
                pend     <= 1'b1;
                pend_err <= (RX_DATA != sum_q);
            end
`endif
        end
    end

endmodule
